// File: rtl/video_timing_pkg.sv
// Video timing package: raster phase type, default 1280x720@60 timing
// and a width helper shared by the raster generator and its axis counters.
package video_timing_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FP     = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BP     = 2'd3
  } phase_t;

  localparam int H_ACTIVE_DEF = 1280;
  localparam int H_FP_DEF     = 110;
  localparam int H_SYNC_DEF   = 40;
  localparam int H_BP_DEF     = 220;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 720;
  localparam int V_FP_DEF     = 5;
  localparam int V_SYNC_DEF   = 5;
  localparam int V_BP_DEF     = 20;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int FC_MAX_DEF   = 60;

  // Bits needed to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: a wrap-by-compare counter plus its ACTIVE/FP/SYNC/BP
// phase FSM. The phase always describes the value currently in count.
module video_axis_counter
  import video_timing_pkg::*;
#(
  parameter int TOTAL  = H_TOTAL_DEF,
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  localparam int W     = cnt_width(TOTAL)
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         advance,
  output logic [W-1:0] count,
  output phase_t       phase,
  output logic         wrap
);

  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] AT_FP   = W'(ACTIVE);
  localparam logic [W-1:0] AT_SYNC = W'(ACTIVE + FP);
  localparam logic [W-1:0] AT_BP   = W'(ACTIVE + FP + SYNC);

  logic [W-1:0] count_reg, count_next;
  phase_t       phase_reg, phase_next;

  assign wrap  = advance && (count_reg == LAST);
  assign count = count_reg;
  assign phase = phase_reg;

  // Next count and phase: boundaries are detected on the value being loaded
  always_comb begin
    count_next = count_reg;
    phase_next = phase_reg;
    if (advance) begin
      count_next = (count_reg == LAST) ? '0 : count_reg + W'(1);
      unique case (phase_reg)
        PH_ACTIVE: if (count_next == AT_FP)   phase_next = PH_FP;
        PH_FP:     if (count_next == AT_SYNC) phase_next = PH_SYNC;
        PH_SYNC:   if (count_next == AT_BP)   phase_next = PH_BP;
        PH_BP:     if (wrap)                  phase_next = PH_ACTIVE;
      endcase
    end
  end

  // Counter and phase state registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count_reg <= '0;
      phase_reg <= PH_ACTIVE;
    end else begin
      count_reg <= count_next;
      phase_reg <= phase_next;
    end
  end

endmodule

// File: rtl/video_sig_gen.sv
// Raster timing generator feeding the TMDS encoders: pixel coordinates,
// syncs, active-draw and new-frame pulse, all registered one cycle behind
// the internal axis counters.
// Optional: define FRAME_COUNT_EN to add the fc_out frame counter (mod FC_MAX).
module video_sig_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int FC_MAX   = FC_MAX_DEF,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = cnt_width(H_TOTAL),
  localparam int VW      = cnt_width(V_TOTAL),
  localparam int FW      = cnt_width(FC_MAX)
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  output logic [HW-1:0] hcount_out,
  output logic [VW-1:0] vcount_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic          ad_out,
  output logic          nf_out
`ifdef FRAME_COUNT_EN
  ,
  output logic [FW-1:0] fc_out
`endif
);

  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;
  phase_t        h_phase, v_phase;
  logic          line_tick;
  logic          frame_wrap_unused;
  logic          nf_next;

  // A frame counter needs at least two states to be meaningful
  if (FC_MAX < 2) begin : g_fc_max_check
    $error("FC_MAX must be at least 2");
  end

  video_axis_counter #(
    .TOTAL (H_TOTAL),
    .ACTIVE(H_ACTIVE),
    .FP    (H_FP),
    .SYNC  (H_SYNC)
  ) u_h_axis (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .advance (1'b1),
    .count   (h_count),
    .phase   (h_phase),
    .wrap    (line_tick)
  );

  // Frame end is implied by the h/v counts, so the v wrap is not consumed
  video_axis_counter #(
    .TOTAL (V_TOTAL),
    .ACTIVE(V_ACTIVE),
    .FP    (V_FP),
    .SYNC  (V_SYNC)
  ) u_v_axis (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .advance (line_tick),
    .count   (v_count),
    .phase   (v_phase),
    .wrap    (frame_wrap_unused)
  );

  // First pixel of the first blanking line marks the new frame
  assign nf_next = (h_count == '0) && (v_count == VW'(V_ACTIVE));

  // Output register stage: coordinates and decoded flags, latency 1
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hs_out     <= 1'b0;
      vs_out     <= 1'b0;
      ad_out     <= 1'b0;
      nf_out     <= 1'b0;
    end else begin
      hcount_out <= h_count;
      vcount_out <= v_count;
      hs_out     <= (h_phase == PH_SYNC);
      vs_out     <= (v_phase == PH_SYNC);
      ad_out     <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
      nf_out     <= nf_next;
    end
  end

`ifdef FRAME_COUNT_EN
  localparam logic [FW-1:0] FC_LAST = FW'(FC_MAX - 1);

  // Frame counter steps on the same edge that raises nf_out
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fc_out <= '0;
    end else if (nf_next) begin
      fc_out <= (fc_out == FC_LAST) ? '0 : fc_out + FW'(1);
    end
  end
`else
  // Frame counter not built: no fc_out port and no counter register
`endif

endmodule
